ctrl_pkt_gen: RTL and testbench

Control-packet transmitter for the RMT control path. It accepts single configuration commands (target module, resource, entry address, entry data) on a valid/ready command port. It serialises each command into a UDP/IPv4 control packet on a 512-bit AXI Stream master. That stream is merged ahead of pkt_filter, and pkt_filter steers the packet to the parser/stage/deparser control chain. The block is the sending end of the control packets that those modules consume.

---
 rtl/rmt_ctrl_pkg.sv | 61 ++++++
 rtl/ctrl_hdr_build.sv | 43 ++++
 rtl/ctrl_pkt_gen.sv | 167 ++++++++++++++++
 tb/tb_ctrl_pkt_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_ctrl_pkg.sv
// Shared control-path definitions: control packet header layout, fixed
// addressing constants and module IDs used by the generator and the decoders.
package rmt_ctrl_pkg;

    localparam int unsigned AXIS_W = 512;

    localparam logic [15:0] CTRL_UDP_PORT  = 16'hF1F2;
    localparam logic [7:0]  MOD_PARSER     = 8'h00;
    localparam logic [7:0]  MOD_STAGE_BASE = 8'h10;
    localparam logic [7:0]  MOD_DEPARSER   = 8'h20;

    localparam int unsigned OFF_DST_MAC   = 32'd0;
    localparam int unsigned OFF_SRC_MAC   = 32'd6;
    localparam int unsigned OFF_ETHTYPE   = 32'd12;
    localparam int unsigned OFF_IP_VIHL   = 32'd14;
    localparam int unsigned OFF_IP_LEN    = 32'd16;
    localparam int unsigned OFF_IP_TTL    = 32'd22;
    localparam int unsigned OFF_IP_PROTO  = 32'd23;
    localparam int unsigned OFF_IP_SRC    = 32'd26;
    localparam int unsigned OFF_IP_DST    = 32'd30;
    localparam int unsigned OFF_UDP_SPORT = 32'd34;
    localparam int unsigned OFF_UDP_DPORT = 32'd36;
    localparam int unsigned OFF_UDP_LEN   = 32'd38;
    localparam int unsigned OFF_MOD_ID    = 32'd42;
    localparam int unsigned OFF_RES_ID    = 32'd43;
    localparam int unsigned OFF_ADDR      = 32'd44;
    localparam int unsigned OFF_SEQ       = 32'd46;

    localparam logic [47:0] DST_MAC        = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC        = 48'h0000_0000_0001;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [31:0] IP_SRC         = 32'h0A00_0001;
    localparam logic [31:0] IP_DST         = 32'h0A00_0002;
    localparam logic [15:0] UDP_SPORT      = 16'h0F0F;
    localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
    localparam logic [15:0] IP_HDR_LEN     = 16'd20;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ctrl_state_e;

    // Writes nbytes of val into beat at byte offset off, MSB at the lowest byte.
    function automatic logic [AXIS_W-1:0] put_be(
        input logic [AXIS_W-1:0] beat,
        input int unsigned       off,
        input int unsigned       nbytes,
        input logic [63:0]       val
    );
        logic [AXIS_W-1:0] res;
        res = beat;
        for (int unsigned i = 0; i < nbytes; i++) begin
            res[8*(off+i) +: 8] = val[8*(nbytes-1-i) +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ctrl_hdr_build.sv
// Combinational builder for the Ethernet/IPv4/UDP header beat of a control
// packet; IP and UDP checksums are left at zero.
module ctrl_hdr_build
    import rmt_ctrl_pkg::*;
#(
    parameter logic [15:0] UDP_DPORT = CTRL_UDP_PORT
) (
    input  logic [7:0]        mod_id,
    input  logic [3:0]        res_id,
    input  logic [15:0]       addr,
    input  logic [15:0]       seq,
    input  logic [15:0]       pkt_len,
    output logic [AXIS_W-1:0] hdr
);

    logic [15:0] ip_len_s;
    logic [15:0] udp_len_s;

    assign ip_len_s  = pkt_len - ETH_HDR_LEN;
    assign udp_len_s = ip_len_s - IP_HDR_LEN;

    // Header beat assembly; every byte not written stays zero.
    always_comb begin
        hdr = '0;
        hdr = put_be(hdr, OFF_DST_MAC,   32'd6, 64'(DST_MAC));
        hdr = put_be(hdr, OFF_SRC_MAC,   32'd6, 64'(SRC_MAC));
        hdr = put_be(hdr, OFF_ETHTYPE,   32'd2, 64'(ETHERTYPE_IPV4));
        hdr = put_be(hdr, OFF_IP_VIHL,   32'd1, 64'(IP_VER_IHL));
        hdr = put_be(hdr, OFF_IP_LEN,    32'd2, 64'(ip_len_s));
        hdr = put_be(hdr, OFF_IP_TTL,    32'd1, 64'(IP_TTL));
        hdr = put_be(hdr, OFF_IP_PROTO,  32'd1, 64'(IP_PROTO_UDP));
        hdr = put_be(hdr, OFF_IP_SRC,    32'd4, 64'(IP_SRC));
        hdr = put_be(hdr, OFF_IP_DST,    32'd4, 64'(IP_DST));
        hdr = put_be(hdr, OFF_UDP_SPORT, 32'd2, 64'(UDP_SPORT));
        hdr = put_be(hdr, OFF_UDP_DPORT, 32'd2, 64'(UDP_DPORT));
        hdr = put_be(hdr, OFF_UDP_LEN,   32'd2, 64'(udp_len_s));
        hdr = put_be(hdr, OFF_MOD_ID,    32'd1, 64'(mod_id));
        hdr = put_be(hdr, OFF_RES_ID,    32'd1, 64'({4'h0, res_id}));
        hdr = put_be(hdr, OFF_ADDR,      32'd2, 64'(addr));
        hdr = put_be(hdr, OFF_SEQ,       32'd2, 64'(seq));
    end

endmodule

// File: rtl/ctrl_pkt_gen.sv
// Control-packet transmitter: serialises one configuration command into a
// header beat plus DATA_BEATS payload beats on a 512-bit AXI Stream master.
module ctrl_pkt_gen #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          CMD_DATA_WIDTH       = 1024,
    parameter logic [7:0]  SRC_PORT             = 8'h01,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [7:0]                        cmd_mod_id,
    input  logic [3:0]                        cmd_res_id,
    input  logic [15:0]                       cmd_addr,
    input  logic [CMD_DATA_WIDTH-1:0]         cmd_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic                              busy,
    output logic [15:0]                       seq_num
);
    import rmt_ctrl_pkg::*;

    localparam int DW         = C_S_AXIS_DATA_WIDTH;
    localparam int KW         = C_S_AXIS_DATA_WIDTH / 8;
    localparam int DATA_BEATS = CMD_DATA_WIDTH / C_S_AXIS_DATA_WIDTH;
    localparam int CNT_W      = $clog2(DATA_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_BEATS);
    localparam logic [15:0] PKT_LEN = 16'((1 + DATA_BEATS) * KW);
    localparam logic [C_S_AXIS_TUSER_WIDTH-1:0] TUSER_PKT =
        {{(C_S_AXIS_TUSER_WIDTH-24){1'b0}}, SRC_PORT, PKT_LEN};

    ctrl_state_e              state_q, state_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [CMD_DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]              seq_q, seq_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     busy_q, busy_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic [DW-1:0]            tdata_q, tdata_d;
    logic [KW-1:0]            tkeep_q, tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [AXIS_W-1:0]        hdr_s;
    logic                     accept_s, hs_s, last_hs_s;

    // The header is built straight from the command port so it can be
    // registered on the acceptance edge; payload is latched for later beats.
    ctrl_hdr_build #(
        .UDP_DPORT (CTRL_UDP_PORT)
    ) u_hdr (
        .mod_id  (cmd_mod_id),
        .res_id  (cmd_res_id),
        .addr    (cmd_addr),
        .seq     (seq_q),
        .pkt_len (PKT_LEN),
        .hdr     (hdr_s)
    );

    assign accept_s  = (state_q == S_IDLE) & cmd_ready_q & cmd_valid;
    assign hs_s      = tvalid_q & m_axis_tready;
    assign last_hs_s = hs_s & (beat_cnt_q == LAST_BEAT);

    // State register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_SEND;
                else          state_d = S_IDLE;
            end
            S_SEND: begin
                if (last_hs_s) state_d = S_IDLE;
                else           state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat sequencing and next values for the registered outputs.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        seq_d      = seq_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tuser_d    = tuser_q;
        if (accept_s) begin
            beat_cnt_d = '0;
            data_d     = cmd_data;
            tvalid_d   = 1'b1;
            tlast_d    = (LAST_BEAT == '0);
            tdata_d    = hdr_s;
            tkeep_d    = '1;
            tuser_d    = TUSER_PKT;
        end else if (last_hs_s) begin
            seq_d    = seq_q + 16'd1;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tuser_d  = '0;
        end else if (hs_s) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            tdata_d    = data_q[DW-1:0];
            data_d     = data_q >> DW;
            tlast_d    = ((beat_cnt_q + CNT_W'(1)) == LAST_BEAT);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d == S_SEND);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            beat_cnt_q  <= '0;
            data_q      <= '0;
            seq_q       <= 16'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            data_q      <= data_d;
            seq_q       <= seq_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign seq_num       = seq_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Bench for ctrl_pkt_gen: directed scenarios plus random traffic, scored
// against a byte-level packet model and a per-cycle handshake model.
module tb_ctrl_pkt_gen;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int CW = 1024;
    localparam int NB = CW / DW;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_mod_id;
    logic [3:0]      cmd_res_id;
    logic [15:0]     cmd_addr;
    logic [CW-1:0]   cmd_data;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            busy;
    logic [15:0]     seq_num;

    always #5 clk = ~clk;

    ctrl_pkt_gen #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .CMD_DATA_WIDTH       (CW),
        .SRC_PORT             (8'h01),
        .CTRL_UDP_PORT        (16'hF1F2)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mod_id    (cmd_mod_id),
        .cmd_res_id    (cmd_res_id),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .seq_num       (seq_num)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] m_seq;
    int          n_checks;
    int          n_fail;

    logic [7:0]    nx_mod;
    logic [3:0]    nx_res;
    logic [15:0]   nx_addr;
    logic [CW-1:0] nx_data;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Header as a list of bytes, laid out straight from the packet format.
    function automatic logic [DW-1:0] exp_hdr(input logic [7:0] mod, input logic [3:0] res,
                                              input logic [15:0] addr, input logic [15:0] seq);
        logic [7:0]    b [64];
        logic [15:0]   ip_len;
        logic [15:0]   udp_len;
        logic [DW-1:0] r;
        ip_len  = 16'(64 * (1 + NB) - 14);
        udp_len = ip_len - 16'd20;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) b[i] = 8'hFF;
        b[11] = 8'h01;
        b[12] = 8'h08;
        b[14] = 8'h45;
        b[16] = ip_len[15:8];  b[17] = ip_len[7:0];
        b[22] = 8'h40;         b[23] = 8'h11;
        b[26] = 8'h0A;         b[29] = 8'h01;
        b[30] = 8'h0A;         b[33] = 8'h02;
        b[34] = 8'h0F;         b[35] = 8'h0F;
        b[36] = 8'hF1;         b[37] = 8'hF2;
        b[38] = udp_len[15:8]; b[39] = udp_len[7:0];
        b[42] = mod;
        b[43] = {4'h0, res};
        b[44] = addr[15:8];    b[45] = addr[7:0];
        b[46] = seq[15:8];     b[47] = seq[7:0];
        for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic push_pkt(input logic [7:0] mod, input logic [3:0] res,
                            input logic [15:0] addr, input logic [CW-1:0] data);
        exp_q.push_back('{data: exp_hdr(mod, res, addr, m_seq), last: 1'b0});
        for (int k = 1; k <= NB; k++) begin
            exp_q.push_back('{data: data[DW*(k-1) +: DW], last: (k == NB)});
        end
    endtask

    task automatic rand_cmd();
        nx_mod  = 8'($urandom);
        nx_res  = 4'($urandom);
        nx_addr = 16'($urandom);
        for (int i = 0; i < CW / 32; i++) nx_data[32*i +: 32] = $urandom;
    endtask

    // One clock: check outputs against the model, drive the next inputs,
    // then advance the model by what the coming edge will do.
    task automatic tick(input logic rst_n_nx, input logic cv_nx, input logic tr_nx);
        logic          exp_rdy;
        logic [UW-1:0] exp_tuser;
        beat_t         b;
        @(negedge clk);
        exp_tuser        = '0;
        exp_tuser[15:0]  = 16'(64 * (1 + NB));
        exp_tuser[23:16] = 8'h01;
        exp_rdy = aresetn && (exp_q.size() == 0);
        chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        chk("cmd_ready", cmd_ready, exp_rdy);
        chk("seq_num", seq_num, m_seq);
        if (exp_q.size() != 0) begin
            chk("tdata", m_axis_tdata, exp_q[0].data);
            chk("tlast", m_axis_tlast, exp_q[0].last);
            chk("tkeep", m_axis_tkeep, {64{1'b1}});
            chk("tuser", m_axis_tuser, exp_tuser);
        end else if (!aresetn) begin
            chk("rst_tdata", m_axis_tdata, '0);
            chk("rst_tkeep", m_axis_tkeep, '0);
            chk("rst_tuser", m_axis_tuser, '0);
            chk("rst_tlast", m_axis_tlast, 1'b0);
        end
        aresetn       = rst_n_nx;
        cmd_valid     = cv_nx;
        m_axis_tready = tr_nx;
        cmd_mod_id    = nx_mod;
        cmd_res_id    = nx_res;
        cmd_addr      = nx_addr;
        cmd_data      = nx_data;
        if (!rst_n_nx) begin
            exp_q.delete();
            m_seq = 16'd0;
        end else begin
            if (exp_q.size() != 0 && tr_nx) begin
                b = exp_q.pop_front();
                if (b.last) m_seq = m_seq + 16'd1;
            end
            if (cv_nx && exp_rdy) push_pkt(nx_mod, nx_res, nx_addr, nx_data);
        end
    endtask

    initial begin
        logic [0:5] bp_pat;
        n_checks = 0;
        n_fail   = 0;
        m_seq    = 16'd0;
        aresetn = 1'b0; cmd_valid = 1'b0; m_axis_tready = 1'b0;
        nx_mod = 8'h00; nx_res = 4'h0; nx_addr = 16'h0000; nx_data = '0;
        cmd_mod_id = 8'h00; cmd_res_id = 4'h0; cmd_addr = 16'h0000; cmd_data = '0;

        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // Single command right after reset release
        nx_mod = 8'h10; nx_res = 4'h2; nx_addr = 16'h0005;
        for (int i = 0; i < CW / 32; i++) nx_data[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // Backpressure pattern during one packet
        rand_cmd();
        tick(1'b1, 1'b1, 1'b1);
        bp_pat = 6'b100101;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, bp_pat[i]);
        repeat (3) tick(1'b1, 1'b0, 1'b1);

        // Back-to-back commands with cmd_valid held high
        for (int i = 0; i < 16; i++) begin
            rand_cmd();
            tick(1'b1, 1'b1, 1'b1);
        end
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // Sequence wrap, starting from a preloaded 0xFFFE
        force dut.seq_q = 16'hFFFE;
        m_seq = 16'hFFFE;
        tick(1'b1, 1'b0, 1'b1);
        release dut.seq_q;
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            rand_cmd();
            tick(1'b1, 1'b1, 1'b1);
        end
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // Reset after the first payload beat handshake
        rand_cmd();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        rand_cmd();
        tick(1'b1, 1'b1, 1'b1);
        repeat (5) tick(1'b1, 1'b0, 1'b1);

        // New commands presented while a stalled packet is in flight
        rand_cmd();
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_cmd();
            tick(1'b1, 1'b1, 1'b0);
        end
        repeat (6) tick(1'b1, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_cmd();
            tick(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0));
        end
        repeat (8) tick(1'b1, 1'b0, 1'b1);
        chk("drain", 512'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
